// File: rtl/onchip_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_arb_pkg
//  Description : Shared constants and types for the two-requester on-chip
//                memory arbiter (default widths, requester id type).
//  Macro       : ONCHIP_MEM_ARB_FIXED_PRIORITY_EN (consumed by rr_arbiter2)
//  Revision    : 1.0 - initial release
// ============================================================================
package onchip_mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  // Identifies one of the two requesters (0 or 1).
  typedef logic [0:0] req_id_t;

endpackage : onchip_mem_arb_pkg
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way grant logic with last_grant register. Grant is
//                combinational from the pending set and last_grant.
//  Macro       : ONCHIP_MEM_ARB_FIXED_PRIORITY_EN - when defined, requester 0
//                always wins contention and last_grant stays at its reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  req_id_t last_grant_q;
  req_id_t last_grant_d;

  // Grant selection and last_grant next-state.
  always_comb begin
    gnt_valid    = (req != 2'b00) && !reset;
    gnt_id       = 1'b0;
    last_grant_d = last_grant_q;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      // Under contention the requester that did not win last time goes next.
      // In the fixed-priority build last_grant is pinned to 1, so this
      // always selects requester 0.
      2'b11:   gnt_id = ~last_grant_q;
      default: gnt_id = 1'b0;
    endcase
`ifdef ONCHIP_MEM_ARB_FIXED_PRIORITY_EN
    last_grant_d = 1'b1;
`else
    if (gnt_valid) begin
      last_grant_d = gnt_id;
    end
`endif
  end

  // last_grant register; reset value 1 lets requester 0 win first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_arbiter
//  Description : Arbitrates two Avalon-MM style requesters onto one
//                single-port on-chip RAM with 1-cycle read latency, and routes
//                read data back to the requester that issued the read.
//  Macro       : ONCHIP_MEM_ARB_FIXED_PRIORITY_EN (see rr_arbiter2)
//  Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  // requester 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_read,
  input  logic                m0_write,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_read,
  input  logic                m1_write,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] pend;
  logic       gnt_valid;
  req_id_t    gnt_id;
  logic       win_read;
  logic       win_write;

  logic       rd_pend_q, rd_pend_d;
  req_id_t    rd_id_q,   rd_id_d;

  assign pend = {m1_read | m1_write, m0_read | m0_write};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pend),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Command mux onto the RAM and per-requester handshake.
  always_comb begin
    mem_address    = gnt_id[0] ? m1_address    : m0_address;
    mem_byteenable = gnt_id[0] ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt_id[0] ? m1_writedata  : m0_writedata;
    win_write      = gnt_id[0] ? m1_write      : m0_write;
    win_read       = gnt_id[0] ? m1_read       : m0_read;
    mem_chipselect = gnt_valid;
    mem_write      = gnt_valid & win_write;
    mem_clken      = 1'b1;
    // Stall a pending requester unless it holds the grant; all stalled in reset.
    m0_waitrequest = reset | (pend[0] & ~(gnt_valid & (gnt_id == 1'b0)));
    m1_waitrequest = reset | (pend[1] & ~(gnt_valid & (gnt_id == 1'b1)));
    // Read+write together behaves as a write, so it never expects read data.
    rd_pend_d      = gnt_valid & win_read & ~win_write;
    rd_id_d        = gnt_id;
  end

  // Outstanding-read tracker: one slot suffices with fixed 1-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Read return routing; gated by reset so a read issued just before reset
  // is dropped.
  always_comb begin
    m0_readdatavalid = rd_pend_q & ~reset & (rd_id_q == 1'b0);
    m1_readdatavalid = rd_pend_q & ~reset & (rd_id_q == 1'b1);
    m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  end

endmodule : onchip_mem_arbiter
`default_nettype wire
